ins_fetch_sequencer: RTL and testbench
======================================

Name: ins_fetch_sequencer

Overview:
- Upstream instruction-fetch stage of the SIMD pipeline.
- Walks a program counter through the instruction BRAM (1-cycle read latency) and hands each fetched word to the decoder over a valid/ready interface.
- Stops on a HALT opcode or at the end of the address space, then pulses done.
- Buffers up to 2 words so BRAM latency never drops or duplicates an instruction under decoder backpressure.

Parameters:
- INS_ADDR_WIDTH, 8: instruction BRAM address width.
- INS_BRAM_WIDTH, 64: instruction BRAM word width.
- ADDR_WIDTH, 10: data-BRAM operand address width (3 operand fields per instruction).
- OPCODE_WIDTH, 4: opcode field width; must equal the package value.
- HALT_OPCODE, 4'hF: opcode that terminates the program.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin fetching at base_addr
- base_addr  in  INS_ADDR_WIDTH  first instruction address, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at program end
- bram_ins_en  out  1  instruction BRAM read enable
- bram_ins_addr  out  INS_ADDR_WIDTH  instruction BRAM address
- bram_ins_din  in  INS_BRAM_WIDTH  read data, valid 1 cycle after en
- ins_valid  out  1  ins_data/ins_pc hold a valid instruction
- ins_ready  in  1  decoder accepts; transfer when valid&&ready
- ins_data  out  INS_BRAM_WIDTH  instruction word
- ins_pc  out  INS_ADDR_WIDTH  address the instruction was fetched from

Behaviour:
- Reset: all outputs 0; state IDLE; pc 0; FIFO empty; in-flight flag cleared. Any read in flight is discarded. Reset applies immediately mid-program.
- Opcode field: word[3*ADDR_WIDTH +: OPCODE_WIDTH].
- States:
  - IDLE: on start go to FETCH with pc <= base_addr. start in any other state is ignored.
  - FETCH: issue a read (bram_ins_en=1, bram_ins_addr=pc, pc<=pc+1) whenever fifo_count + inflight < 2.
  - DRAIN: no reads issued; wait until the FIFO is empty.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Response: the cycle after an issue, {din, issued address} is pushed into the 2-entry FIFO. The FIFO head drives ins_valid, ins_data and ins_pc; a pop occurs on valid&&ready. Push and pop in the same cycle are legal. Credit counting guarantees the FIFO never overflows.
- HALT handling:
  - A returning word whose opcode == HALT_OPCODE is not pushed.
  - Any later in-flight response is discarded.
  - State moves to DRAIN.
- End of memory: after issuing address 2^INS_ADDR_WIDTH-1, no further reads are issued (no wrap). Once that last response is pushed, state moves to DRAIN. A HALT at the last address behaves as HALT.
- Latency:
  - start to first bram_ins_en: 1 cycle.
  - bram_ins_en to ins_valid: 1 cycle.
  - Sustained throughput: 1 instruction per cycle while ins_ready=1.
- ins_data and ins_pc stay stable while ins_valid && !ins_ready.
- busy stays 1 throughout FETCH and DRAIN.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_ins_cnt[31:0] (count of valid&&ready transfers) and perf_stall_cnt[31:0] (count of cycles with valid && !ready).
  - Both counters clear on reset and on an accepted start, saturate at all-ones, and hold their values after done.
- When undefined: the ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: OPCODE_WIDTH, HALT_OPCODE, the opcode field offset helper, and an fsm typedef enum {IDLE, FETCH, DRAIN, DONE}.
- Sub-module: ins_fetch_fifo, a parameterised 2-entry FIFO of {pc, word} with count output, instantiated once.

Test Plan:
- base_addr=0x10, words 0x10..0x13 are non-HALT and 0x14 is HALT, ins_ready=1 → ins_pc 0x10,0x11,0x12,0x13 on 4 consecutive cycles; HALT word not forwarded; done pulses once; busy falls with done.
- Same program with ins_ready toggling 1,0,0,1 repeatedly → each instruction delivered exactly once and in order; ins_data stable while stalled; bram_ins_en never asserted while FIFO+inflight=2.
- base_addr=0xFE with no HALT → ins_pc 0xFE then 0xFF; no read of 0x00; done follows.
- HALT at base_addr=0x20 → no ins_valid at all; done pulses 3 cycles after start.
- rstn low for 1 cycle mid-program with a read in flight → next cycle all outputs 0; no stale ins_valid; a fresh start at 0x00 fetches correctly.
- start pulsed while busy → ignored; pc sequence unaffected. With FETCH_PERF_CNT_EN in the stall scenario, perf_ins_cnt equals the number of instructions and perf_stall_cnt equals the number of cycles with ins_valid=1 and ins_ready=0.

Source files
------------

// File: rtl/ins_fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: opcode field
// geometry, the HALT opcode and the sequencer FSM state type.
package ins_fetch_sequencer_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  // The opcode sits directly above the three operand address fields.
  function automatic int opcode_lsb(input int addr_width);
    return 3 * addr_width;
  endfunction

endpackage

// File: rtl/ins_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its instruction BRAM and the
// decoder. The master modport is the sequencer side.
interface ins_fetch_sequencer_if #(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_BRAM_WIDTH = 64
) ();

  logic                      bram_ins_en;
  logic [INS_ADDR_WIDTH-1:0] bram_ins_addr;
  logic [INS_BRAM_WIDTH-1:0] bram_ins_din;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [INS_BRAM_WIDTH-1:0] ins_data;
  logic [INS_ADDR_WIDTH-1:0] ins_pc;

  modport master (
    output bram_ins_en, bram_ins_addr, ins_valid, ins_data, ins_pc,
    input  bram_ins_din, ins_ready
  );

  modport slave (
    input  bram_ins_en, bram_ins_addr, ins_valid, ins_data, ins_pc,
    output bram_ins_din, ins_ready
  );

endinterface

// File: rtl/ins_fetch_fifo.sv
// Two-entry fall-through FIFO of {pc, word}. When empty, a pushed entry is
// presented on the output in the same cycle and is only stored if it is not
// popped, so the BRAM response reaches the decoder with no extra latency.
module ins_fetch_fifo #(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count,
  output logic [1:0]       o_count_next
);

  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic w_empty;
  logic w_store;
  logic w_take;

  assign w_empty = (r_count == 2'd0);
  // An entry consumed straight off the input never occupies storage.
  assign w_store = i_push && !(w_empty && i_pop);
  assign w_take  = i_pop && !w_empty;

  assign o_valid      = !w_empty || i_push;
  assign o_data       = !w_empty ? r_mem[r_rd_ptr] : (i_push ? i_data : '0);
  assign o_count      = r_count;
  assign o_count_next = r_count + {1'b0, w_store} - {1'b0, w_take};

  // Storage write; the caller's credit scheme keeps this from overflowing.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) r_wr_ptr <= ~r_wr_ptr;
      if (w_take)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/ins_fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC through the instruction BRAM,
// forwards each word to the decoder over valid/ready, stops on HALT or at
// the top of the address space, then pulses done.
// Optional macro FETCH_PERF_CNT_EN adds transfer and stall counters.
module ins_fetch_sequencer
  import ins_fetch_sequencer_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int INS_BRAM_WIDTH = 64,
  parameter int ADDR_WIDTH     = 10,
  // Must stay equal to the package value so the decoder agrees on the field.
  parameter int OPCODE_WIDTH   = ins_fetch_sequencer_pkg::OPCODE_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = ins_fetch_sequencer_pkg::HALT_OPCODE
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] base_addr,
  output logic                      busy,
  output logic                      done,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]               perf_ins_cnt,
  output logic [31:0]               perf_stall_cnt,
`endif
  ins_fetch_sequencer_if.master     ins_bus
);

  localparam int OPC_LSB = opcode_lsb(ADDR_WIDTH);
  localparam int FIFO_W  = INS_ADDR_WIDTH + INS_BRAM_WIDTH;

  fsm_t                      r_state;
  logic [INS_ADDR_WIDTH-1:0] r_pc;
  logic [INS_ADDR_WIDTH-1:0] r_issue_pc;
  logic                      r_inflight;
  logic                      r_end;
  logic                      r_busy;
  logic                      r_done;

  logic              w_issue;
  logic              w_resp;
  logic              w_halt;
  logic              w_push;
  logic              w_last;
  logic              w_valid;
  logic              w_pop;
  logic [1:0]        w_count;
  logic [1:0]        w_count_next;
  logic [1:0]        w_credit;
  logic [FIFO_W-1:0] w_head;

  // Buffered words plus the read in flight may never exceed the FIFO depth.
  assign w_credit = w_count + {1'b0, r_inflight};
  assign w_issue  = (r_state == FETCH) && !r_end && (w_credit < 2'd2);

  // Responses are only honoured while fetching; after HALT or reset they drop.
  assign w_resp = r_inflight && (r_state == FETCH);
  assign w_halt = w_resp &&
                  (ins_bus.bram_ins_din[OPC_LSB +: OPCODE_WIDTH] == HALT_OPCODE);
  assign w_push = w_resp && !w_halt;
  // r_end with a response pending means this is the last address's word.
  assign w_last = w_halt || (w_resp && r_end);
  assign w_pop  = w_valid && ins_bus.ins_ready;

  ins_fetch_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .i_push       (w_push),
    .i_data       ({r_issue_pc, ins_bus.bram_ins_din}),
    .i_pop        (w_pop),
    .o_valid      (w_valid),
    .o_data       (w_head),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  assign ins_bus.bram_ins_en   = w_issue;
  assign ins_bus.bram_ins_addr = r_pc;
  assign ins_bus.ins_valid     = w_valid;
  assign ins_bus.ins_data      = w_head[INS_BRAM_WIDTH-1:0];
  assign ins_bus.ins_pc        = w_head[FIFO_W-1 -: INS_ADDR_WIDTH];
  assign busy                  = r_busy;
  assign done                  = r_done;

  // Sequencer FSM with PC, in-flight tracking and registered busy/done.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
      r_end      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc       <= r_pc + INS_ADDR_WIDTH'(1);
        r_issue_pc <= r_pc;
        if (r_pc == '1) r_end <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= base_addr;
            r_end   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (w_last) begin
            if (w_count_next == 2'd0) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_count_next == 2'd0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_ins;
  logic [31:0] r_perf_stall;
  logic        w_start_ok;

  assign w_start_ok     = start && (r_state == IDLE);
  assign perf_ins_cnt   = r_perf_ins;
  assign perf_stall_cnt = r_perf_stall;

  // Saturating transfer and stall counters, cleared per program.
  always_ff @(posedge clk) begin
    if (!rstn || w_start_ok) begin
      r_perf_ins   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop && (r_perf_ins != '1))
        r_perf_ins <= r_perf_ins + 32'd1;
      if (w_valid && !ins_bus.ins_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_fetch_sequencer.sv
// Scoreboard bench for ins_fetch_sequencer: expected {pc, word} pairs are
// queued when a program is started and checked at each decoder handshake.
module tb_ins_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] base_addr;
  logic       busy;
  logic       done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_ins_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ins_fetch_sequencer_if #(.INS_ADDR_WIDTH(8), .INS_BRAM_WIDTH(64)) bus ();

  ins_fetch_sequencer dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .base_addr      (base_addr),
    .busy           (busy),
    .done           (done),
`ifdef FETCH_PERF_CNT_EN
    .perf_ins_cnt   (perf_ins_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .ins_bus        (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:255];
  logic [71:0] q [$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int n_issue, n_xfer, n_stall, n_done, n_exp;
  int done_cyc, start_cyc, last_xfer_cyc, exp_issue;
  bit b2b_en, have_xfer;
  bit prev_stall = 1'b0;
  bit prev_busy = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Opcode sits at 3*10 = bit 30.
  function automatic bit is_halt(input logic [63:0] w);
    return w[33:30] == 4'hF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction BRAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.bram_ins_en) bus.bram_ins_din <= mem[bus.bram_ins_addr];
  end

  // Decoder ready: always high, or the repeating pattern 1,0,0,1.
  initial begin
    bus.ins_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        case (cyc % 4)
          0: bus.ins_ready = 1'b1;
          1: bus.ins_ready = 1'b0;
          2: bus.ins_ready = 1'b0;
          default: bus.ins_ready = 1'b1;
        endcase
      end else begin
        bus.ins_ready = 1'b1;
      end
    end
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.bram_ins_en) begin
        check("issue_addr", 64'(bus.bram_ins_addr), 64'(exp_issue));
        check("credit_ok", 64'((n_issue - n_xfer) < 2), 64'd1);
        exp_issue++;
        n_issue++;
      end
      if (prev_stall) begin
        check("stall_valid", 64'(bus.ins_valid), 64'd1);
        check("stall_data", bus.ins_data, prev_data);
        check("stall_pc", 64'(bus.ins_pc), 64'(prev_pc));
      end
      if (bus.ins_valid && bus.ins_ready) begin
        logic [71:0] item;
        $display("xfer pc=%02h data=%016h cyc=%0d", bus.ins_pc, bus.ins_data, cyc);
        check("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          item = q.pop_front();
          check("ins_pc", 64'(bus.ins_pc), 64'(item[71:64]));
          check("ins_data", bus.ins_data, item[63:0]);
        end
        if (b2b_en && have_xfer) check("back_to_back", 64'(cyc - last_xfer_cyc), 64'd1);
        have_xfer = 1'b1;
        last_xfer_cyc = cyc;
        n_xfer++;
      end
      prev_stall = bus.ins_valid && !bus.ins_ready;
      if (prev_stall) n_stall++;
      prev_data = bus.ins_data;
      prev_pc = bus.ins_pc;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("busy_at_done", 64'(busy), 64'd0);
        check("busy_before_done", 64'(prev_busy), 64'd1);
      end
      prev_busy = busy;
    end else begin
      prev_stall = 1'b0;
      prev_busy = 1'b0;
    end
  end

  // Queue the expected program and pulse start.
  task automatic kick(input logic [7:0] base);
    q.delete();
    for (int a = int'(base); a < 256; a++) begin
      if (is_halt(mem[a])) break;
      q.push_back({8'(a), mem[a]});
    end
    n_exp = q.size();
    n_issue = 0; n_xfer = 0; n_stall = 0; n_done = 0;
    have_xfer = 1'b0;
    exp_issue = int'(base);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("first_en", 64'(bus.bram_ins_en), 64'd1);
  endtask

  task automatic run_program(input logic [7:0] base, input int mode, input bit b2b,
                             input bit poke, input int lat);
    ready_mode = mode;
    b2b_en = b2b;
    kick(base);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1; base_addr = 8'h40;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 300; i++) begin
      if (n_done != 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_count", 64'(n_done), 64'd1);
    check("sb_drained", 64'(q.size()), 64'd0);
    check("xfer_count", 64'(n_xfer), 64'(n_exp));
    if (lat >= 0) check("done_latency", 64'(done_cyc - start_cyc), 64'(lat));
`ifdef FETCH_PERF_CNT_EN
    check("perf_ins", 64'(perf_ins_cnt), 64'(n_xfer));
    check("perf_stall", 64'(perf_stall_cnt), 64'(n_stall));
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"}, 64'(bus.bram_ins_en), 64'd0);
    check({tag, "_addr"}, 64'(bus.bram_ins_addr), 64'd0);
    check({tag, "_valid"}, 64'(bus.ins_valid), 64'd0);
    check({tag, "_data"}, bus.ins_data, 64'd0);
    check({tag, "_pc"}, 64'(bus.ins_pc), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    for (int a = 0; a < 256; a++) begin
      w = {32'hC0DE_0000 | 32'(a), 32'h5A00_0000 ^ (32'(a) * 32'h0101_0101)};
      w[33:30] = 4'(a % 15);
      mem[a] = w;
    end
    mem[8'h14][33:30] = 4'hF;
    mem[8'h20][33:30] = 4'hF;
    mem[8'h05][33:30] = 4'hF;

    rstn = 1'b0; start = 1'b0; base_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check_idle_outputs("reset");

    run_program(8'h10, 0, 1'b1, 1'b0, -1);   // straight run to HALT
    run_program(8'h10, 1, 1'b0, 1'b1, -1);   // backpressure + ignored start
    run_program(8'hFE, 0, 1'b1, 1'b0, -1);   // end of address space
    run_program(8'h20, 0, 1'b0, 1'b0, 3);    // HALT first

    // Reset mid-program with a read in flight.
    ready_mode = 0;
    b2b_en = 1'b0;
    kick(8'h10);
    @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    check_idle_outputs("midrst");
    repeat (2) begin
      @(posedge clk);
      #1 check("no_stale_valid", 64'(bus.ins_valid), 64'd0);
    end
    q.delete();

    run_program(8'h00, 0, 1'b1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
